traffic_conflict_monitor: RTL and testbench
===========================================

TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 The block SHALL have parameter MIN_YELLOW, default 150_000_000; minimum legal yellow duration in clk cycles.
REQ-002 The block SHALL have parameter MAX_YELLOW, default 160_000_000; maximum legal yellow duration in clk cycles (< 2^28).
REQ-003 The block SHALL have parameter GLITCH_CYCLES, default 4; consecutive cycles an invalid lamp encoding is tolerated.
REQ-004 The block SHALL have parameter FLASH_HALF, default 25_000_000; half-period of the flash output in clk cycles.
REQ-005 The block SHALL have port clk, input, 1: clock.
REQ-006 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 The block SHALL have port highway_light, input, 3: highway lamp drive, {red,yellow,green} one-hot.
REQ-008 The block SHALL have port farm_light, input, 3: farm lamp drive, same encoding.
REQ-009 The block SHALL have port clear_fault, input, 1: single-cycle request to clear a latched fault.
REQ-010 The block SHALL have port monitor_ok, output, 1: high in MONITOR state.
REQ-011 The block SHALL have port fault, output, 1: latched fault flag.
REQ-012 The block SHALL have port fault_code, output, 3: first detected fault cause.
REQ-013 The block SHALL have port flash_red, output, 1: override strobe for red lamps, toggling while faulted.

Function
REQ-014 Both light inputs SHALL be registered once before checking; all checks SHALL use the registered values.
REQ-015 A fault SHALL be visible on fault/fault_code 2 clk edges after the offending input value first appears on the ports.
REQ-016 State machine states SHALL be INIT, MONITOR and FAULT.
REQ-017 INIT SHALL move to MONITOR after GLITCH_CYCLES consecutive samples with both lamps valid and at least one lamp red; INIT SHALL raise no faults.
REQ-018 MONITOR SHALL move to FAULT on any check failure and latch fault_code; FAULT SHALL hold fault_code unchanged until cleared.
REQ-019 Code 1 (conflict) SHALL fire when both lamps are valid and neither is red, with no filtering.
REQ-020 Code 2 (encoding) SHALL fire when a lamp is not one-hot for GLITCH_CYCLES consecutive samples; invalid samples SHALL NOT update that lamp's last-valid colour.
REQ-021 Code 3 (sequence) SHALL fire on any per-lamp valid colour change other than G->Y, Y->R or R->G.
REQ-022 Code 4 (short yellow) SHALL fire on a Y->R change when the yellow count is < MIN_YELLOW.
REQ-023 Code 5 (long yellow) SHALL fire when the yellow count reaches MAX_YELLOW+1.
REQ-024 The yellow count SHALL equal consecutive valid yellow samples, clear on leaving yellow, and saturate at MAX_YELLOW+1.
REQ-025 On simultaneous faults, the lowest code SHALL win.
REQ-026 fault_code SHALL be 0 whenever fault is low.
REQ-027 flash_red SHALL be 0 outside FAULT; in FAULT it SHALL start at 1 and toggle every FLASH_HALF cycles.
REQ-028 clear_fault in FAULT SHALL move to INIT only if the current sample is valid and non-conflicting; otherwise it SHALL be ignored; it SHALL be ignored in INIT and MONITOR.

Reset
REQ-029 Reset SHALL force INIT, fault=0, fault_code=0, flash_red=0, monitor_ok=0, and clear all counters, the input registers and the last-valid colours.
REQ-030 Reset asserted mid-fault or mid-yellow SHALL discard all history, and monitoring SHALL re-arm through INIT.

Structure
REQ-031 Lamp encodings (RED 3'b100, YEL 3'b010, GRN 3'b001), fault codes and state encoding SHALL live in shared package traffic_pkg.
REQ-032 Per-lamp logic (valid check, glitch counter, last colour, yellow counter, sequence/short/long flags) SHALL be sub-module tlc_lamp_checker, instantiated once per road.

Verification
Unless stated otherwise, benches SHALL use MIN_YELLOW=4, MAX_YELLOW=8, GLITCH_CYCLES=2, FLASH_HALF=3.
REQ-033 Legal cycle HG/FR -> HY(5 cycles) -> HR/FG -> FY(5) -> HG -> fault=0 and monitor_ok=1 throughout, after INIT exits 2 cycles after reset release.
REQ-034 In MONITOR, drive highway=001 and farm=001 for 1 cycle -> fault=1, fault_code=1 two edges later; flash_red=1 for 3 cycles, then 0 for 3, repeating.
REQ-035 Highway yellow for 3 cycles then red -> fault_code=4; with yellow held 9 cycles instead -> fault_code=5 at the 9th sample.
REQ-036 Highway=011 for 1 cycle -> no fault; held for 2 cycles -> fault_code=2; highway G->R directly -> fault_code=3.
REQ-037 clear_fault pulse while lamps conflict -> stays FAULT; pulse with HG/FR -> INIT, then MONITOR 2 cycles later; rst_n low mid-FAULT -> all outputs 0 immediately.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared lamp encodings, fault codes, monitor states and lamp helpers
package traffic_pkg;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam int YCW = 28;
    typedef enum logic [2:0] {F_NONE, F_CONFLICT, F_ENCODING, F_SEQUENCE, F_SHORT, F_LONG} fault_code_t;
    typedef enum logic [1:0] {S_INIT, S_MONITOR, S_FAULT} state_t;
    function automatic logic is_onehot(input logic [2:0] l);
        return l == RED || l == YEL || l == GRN;
    endfunction
    function automatic logic legal_step(input logic [2:0] a, input logic [2:0] b);
        return (a == GRN && b == YEL) || (a == YEL && b == RED) || (a == RED && b == GRN);
    endfunction
endpackage

// File: rtl/tlc_lamp_checker.sv
// tlc_lamp_checker: per-road validity, glitch filter, colour history and yellow timing checks
module tlc_lamp_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW    = 150_000_000,
    parameter int MAX_YELLOW    = 160_000_000,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_light,
    output logic       o_valid,
    output logic       o_enc,
    output logic       o_seq,
    output logic       o_short,
    output logic       o_long
);
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    localparam logic [YCW-1:0] YSAT = YCW'(MAX_YELLOW + 1);
    logic [GW-1:0]  r_gcnt;
    logic [2:0]     r_last;
    logic [YCW-1:0] r_ycnt;
    logic [YCW-1:0] w_ycnt;
    logic           w_valid;
    logic           w_chg;
    assign w_valid = is_onehot(i_light);
    assign w_chg   = w_valid && r_last != 3'b000 && i_light != r_last;
    // invalid samples freeze the yellow count rather than ending the yellow phase
    assign w_ycnt  = !w_valid ? r_ycnt : (i_light != YEL) ? '0 : (r_ycnt == YSAT) ? YSAT : r_ycnt + 1'b1;
    assign o_valid = w_valid;
    assign o_enc   = !w_valid && r_gcnt >= GW'(GLITCH_CYCLES - 1);
    assign o_seq   = w_chg && !legal_step(r_last, i_light);
    assign o_short = w_chg && r_last == YEL && i_light == RED && r_ycnt < YCW'(MIN_YELLOW);
    assign o_long  = w_ycnt == YSAT;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_gcnt <= '0;
            r_last <= '0;
            r_ycnt <= '0;
        end else begin
            r_gcnt <= w_valid ? '0 : (r_gcnt == GW'(GLITCH_CYCLES)) ? r_gcnt : r_gcnt + 1'b1;
            r_last <= w_valid ? i_light : r_last;
            r_ycnt <= w_ycnt;
        end
endmodule

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: watches two lamp drives and latches the first safety fault
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW    = 150_000_000,
    parameter int MAX_YELLOW    = 160_000_000,
    parameter int GLITCH_CYCLES = 4,
    parameter int FLASH_HALF    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] highway_light,
    input  logic [2:0] farm_light,
    input  logic       clear_fault,
    output logic       monitor_ok,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_red
);
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    logic [2:0]  r_hw, r_fm;
    logic        w_hw_valid, w_hw_enc, w_hw_seq, w_hw_short, w_hw_long;
    logic        w_fm_valid, w_fm_enc, w_fm_seq, w_fm_short, w_fm_long;
    logic        w_both, w_red, w_conflict, w_safe;
    fault_code_t w_code, r_code;
    state_t      r_state;
    logic [GW-1:0] r_icnt;
    logic [FW-1:0] r_fcnt;
    logic        r_ok, r_fault, r_flash;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_hw <= '0;
            r_fm <= '0;
        end else begin
            r_hw <= highway_light;
            r_fm <= farm_light;
        end
    tlc_lamp_checker #(.MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW), .GLITCH_CYCLES(GLITCH_CYCLES)) u_hw (
        .clk(clk), .rst_n(rst_n), .i_light(r_hw), .o_valid(w_hw_valid), .o_enc(w_hw_enc),
        .o_seq(w_hw_seq), .o_short(w_hw_short), .o_long(w_hw_long)
    );
    tlc_lamp_checker #(.MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW), .GLITCH_CYCLES(GLITCH_CYCLES)) u_fm (
        .clk(clk), .rst_n(rst_n), .i_light(r_fm), .o_valid(w_fm_valid), .o_enc(w_fm_enc),
        .o_seq(w_fm_seq), .o_short(w_fm_short), .o_long(w_fm_long)
    );
    assign w_both     = w_hw_valid && w_fm_valid;
    assign w_red      = r_hw[2] || r_fm[2];
    assign w_conflict = w_both && !w_red;
    assign w_safe     = w_both && w_red;
    assign w_code     = w_conflict ? F_CONFLICT :
                        (w_hw_enc || w_fm_enc) ? F_ENCODING :
                        (w_hw_seq || w_fm_seq) ? F_SEQUENCE :
                        (w_hw_short || w_fm_short) ? F_SHORT :
                        (w_hw_long || w_fm_long) ? F_LONG : F_NONE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= S_INIT;
            r_icnt  <= '0;
            r_fcnt  <= '0;
            r_ok    <= 1'b0;
            r_fault <= 1'b0;
            r_code  <= F_NONE;
            r_flash <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_icnt <= w_safe ? r_icnt + 1'b1 : '0;
                    if (w_safe && r_icnt == GW'(GLITCH_CYCLES - 1)) begin
                        r_state <= S_MONITOR;
                        r_ok    <= 1'b1;
                    end
                end
                S_MONITOR:
                    if (w_code != F_NONE) begin
                        r_state <= S_FAULT;
                        r_ok    <= 1'b0;
                        r_fault <= 1'b1;
                        r_code  <= w_code;
                        r_flash <= 1'b1;
                        r_fcnt  <= '0;
                    end
                S_FAULT: begin
                    r_fcnt  <= (r_fcnt == FW'(FLASH_HALF - 1)) ? '0 : r_fcnt + 1'b1;
                    r_flash <= (r_fcnt == FW'(FLASH_HALF - 1)) ? !r_flash : r_flash;
                    // clearing into a conflict would immediately re-fault, so it waits for a safe sample
                    if (clear_fault && w_safe) begin
                        r_state <= S_INIT;
                        r_icnt  <= '0;
                        r_fault <= 1'b0;
                        r_code  <= F_NONE;
                        r_flash <= 1'b0;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    assign monitor_ok = r_ok;
    assign fault      = r_fault;
    assign fault_code = r_code;
    assign flash_red  = r_flash;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor: directed and random checks against a behavioural reference
module tb_traffic_conflict_monitor;
    localparam int MINY = 4;
    localparam int MAXY = 8;
    localparam int G    = 2;
    localparam int FH   = 3;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] highway_light, farm_light;
    logic       clear_fault;
    logic       monitor_ok, fault, flash_red;
    logic [2:0] fault_code;
    logic [5:0] obs;
    int errors = 0;
    int checks = 0;
    logic [2:0] s_h, s_f;
    logic [2:0] last [2];
    int bad [2];
    int yel [2];
    int mode, ecode, age, good;

    traffic_conflict_monitor #(.MIN_YELLOW(MINY), .MAX_YELLOW(MAXY), .GLITCH_CYCLES(G), .FLASH_HALF(FH)) dut (
        .clk(clk), .rst_n(rst_n), .highway_light(highway_light), .farm_light(farm_light),
        .clear_fault(clear_fault), .monitor_ok(monitor_ok), .fault(fault), .fault_code(fault_code),
        .flash_red(flash_red)
    );

    always #5 clk = ~clk;
    assign obs = {monitor_ok, fault, fault_code, flash_red};

    task automatic model_reset();
        mode = 0; ecode = 0; age = 0; good = 0; s_h = '0; s_f = '0;
        for (int i = 0; i < 2; i++) begin
            last[i] = '0; bad[i] = 0; yel[i] = 0;
        end
    endtask

    // mode: 0 = arming, 1 = monitoring, 2 = faulted; age = cycles spent faulted
    task automatic model(input logic clr);
        logic [2:0] s [2];
        bit v [2];
        bit enc, seq, shrt, lng, conf, safe;
        int code;
        s[0] = s_h; s[1] = s_f;
        enc = 0; seq = 0; shrt = 0; lng = 0;
        for (int i = 0; i < 2; i++) begin
            v[i] = $countones(s[i]) == 1;
            if (!v[i]) begin
                bad[i]++;
                if (bad[i] >= G) enc = 1;
            end else begin
                bad[i] = 0;
                if (last[i] != 3'b000 && s[i] != last[i]) begin
                    if (!((last[i] == 3'b001 && s[i] == 3'b010) || (last[i] == 3'b010 && s[i] == 3'b100) ||
                          (last[i] == 3'b100 && s[i] == 3'b001))) seq = 1;
                    if (last[i] == 3'b010 && s[i] == 3'b100 && yel[i] < MINY) shrt = 1;
                end
                yel[i] = (s[i] == 3'b010) ? yel[i] + 1 : 0;
                last[i] = s[i];
            end
            if (yel[i] > MAXY) lng = 1;
        end
        conf = v[0] && v[1] && !s[0][2] && !s[1][2];
        safe = v[0] && v[1] && (s[0][2] || s[1][2]);
        code = conf ? 1 : enc ? 2 : seq ? 3 : shrt ? 4 : lng ? 5 : 0;
        if (mode == 0) begin
            good = safe ? good + 1 : 0;
            if (good >= G) mode = 1;
        end else if (mode == 1) begin
            if (code != 0) begin mode = 2; ecode = code; age = 0; end
        end else begin
            age++;
            if (clr && safe) begin mode = 0; good = 0; end
        end
    endtask

    function automatic logic [5:0] expected();
        return {mode == 1, mode == 2, (mode == 2) ? 3'(ecode) : 3'd0, mode == 2 && ((age / FH) % 2 == 0)};
    endfunction

    task automatic cyc(input logic [2:0] h, input logic [2:0] f, input logic c);
        highway_light = h; farm_light = f; clear_fault = c;
        @(posedge clk);
        model(c);
        s_h = h; s_f = f;
        @(negedge clk);
    endtask

    task automatic arm();
        @(negedge clk);
        rst_n = 1'b0; highway_light = 3'b001; farm_light = 3'b100; clear_fault = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(3'b001, 3'b100, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; highway_light = '0; farm_light = '0; clear_fault = 1'b0;
        model_reset();
        #3;
        checks++; if (obs !== 6'b0) begin errors++; $display("FAIL reset_outputs got %b exp %b", obs, 6'b0); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(3'b001, 3'b100, 1'b0);
            checks++; if (monitor_ok !== (k == 2)) begin errors++; $display("FAIL init_exit cycle %0d got %b exp %b", k, monitor_ok, k == 2); end
            checks++; if (obs !== expected()) begin errors++; $display("FAIL init_model got %b exp %b", obs, expected()); end
        end
    endtask

    task automatic test_legal_cycle();
        logic [2:0] hs [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b001};
        logic [2:0] fs [5] = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
        int n [5] = '{2, 5, 3, 5, 3};
        arm();
        for (int p = 0; p < 5; p++)
            for (int k = 0; k < n[p]; k++) begin
                cyc(hs[p], fs[p], 1'b0);
                checks++; if ({monitor_ok, fault} !== 2'b10) begin errors++; $display("FAIL legal_cycle phase %0d got ok=%b fault=%b exp ok=1 fault=0", p, monitor_ok, fault); end
            end
        cyc(3'b001, 3'b100, 1'b0);
        checks++; if (obs !== expected()) begin errors++; $display("FAIL legal_model got %b exp %b", obs, expected()); end
    endtask

    task automatic test_conflict();
        arm();
        cyc(3'b001, 3'b001, 1'b0);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL conflict_early got %b exp 0", fault); end
        cyc(3'b001, 3'b100, 1'b0);
        checks++; if ({fault, fault_code, flash_red} !== 5'b10011) begin errors++; $display("FAIL conflict_latch got %b exp 10011", {fault, fault_code, flash_red}); end
        for (int k = 1; k < 12; k++) begin
            cyc(3'b001, 3'b100, 1'b0);
            checks++; if ({fault, fault_code, flash_red} !== {4'b1001, ((k / 3) % 2) == 0}) begin
                errors++; $display("FAIL flash_pattern k=%0d got %b exp %b", k, {fault, fault_code, flash_red}, {4'b1001, ((k / 3) % 2) == 0});
            end
            checks++; if (obs !== expected()) begin errors++; $display("FAIL flash_model got %b exp %b", obs, expected()); end
        end
    endtask

    task automatic test_yellow();
        arm();
        repeat (3) cyc(3'b010, 3'b100, 1'b0);
        cyc(3'b100, 3'b100, 1'b0);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL short_early got %b exp 0", fault); end
        cyc(3'b100, 3'b100, 1'b0);
        checks++; if ({fault, fault_code} !== 4'b1100) begin errors++; $display("FAIL short_yellow got %b exp 1100", {fault, fault_code}); end
        arm();
        for (int k = 1; k <= 10; k++) begin
            cyc(3'b010, 3'b100, 1'b0);
            checks++; if ({fault, fault_code} !== ((k == 10) ? 4'b1101 : 4'b0000)) begin
                errors++; $display("FAIL long_yellow k=%0d got %b exp %b", k, {fault, fault_code}, (k == 10) ? 4'b1101 : 4'b0000);
            end
        end
    endtask

    task automatic test_encoding();
        arm();
        cyc(3'b011, 3'b100, 1'b0);
        repeat (2) cyc(3'b001, 3'b100, 1'b0);
        checks++; if (obs !== 6'b100000) begin errors++; $display("FAIL glitch_tolerated got %b exp 100000", obs); end
        repeat (2) cyc(3'b011, 3'b100, 1'b0);
        cyc(3'b001, 3'b100, 1'b0);
        checks++; if ({fault, fault_code} !== 4'b1010) begin errors++; $display("FAIL encoding got %b exp 1010", {fault, fault_code}); end
        arm();
        repeat (2) cyc(3'b100, 3'b100, 1'b0);
        checks++; if ({fault, fault_code} !== 4'b1011) begin errors++; $display("FAIL sequence got %b exp 1011", {fault, fault_code}); end
    endtask

    task automatic test_clear();
        arm();
        repeat (2) cyc(3'b001, 3'b001, 1'b0);
        cyc(3'b001, 3'b001, 1'b1);
        checks++; if ({fault, fault_code} !== 4'b1001) begin errors++; $display("FAIL clear_ignored got %b exp 1001", {fault, fault_code}); end
        cyc(3'b001, 3'b100, 1'b0);
        cyc(3'b001, 3'b100, 1'b1);
        checks++; if (obs !== 6'b0) begin errors++; $display("FAIL clear_to_init got %b exp 000000", obs); end
        cyc(3'b001, 3'b100, 1'b0);
        checks++; if (monitor_ok !== 1'b0) begin errors++; $display("FAIL rearm_early got %b exp 0", monitor_ok); end
        cyc(3'b001, 3'b100, 1'b0);
        checks++; if (monitor_ok !== 1'b1) begin errors++; $display("FAIL rearm got %b exp 1", monitor_ok); end
        cyc(3'b001, 3'b001, 1'b0);
        cyc(3'b001, 3'b100, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (obs !== 6'b0) begin errors++; $display("FAIL async_reset got %b exp 000000", obs); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(3'b001, 3'b100, 1'b0);
        checks++; if (obs !== 6'b100000) begin errors++; $display("FAIL reset_rearm got %b exp 100000", obs); end
    endtask

    task automatic test_random();
        logic [2:0] col [3] = '{3'b001, 3'b010, 3'b100};
        logic [2:0] h, f;
        h = 3'b001; f = 3'b100;
        arm();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) h = ($urandom_range(0, 9) == 0) ? 3'($urandom) : col[$urandom_range(0, 2)];
            if ($urandom_range(0, 3) == 0) f = ($urandom_range(0, 9) == 0) ? 3'($urandom) : col[$urandom_range(0, 2)];
            cyc(h, f, $urandom_range(0, 6) == 0);
            checks++; if (obs !== expected()) begin errors++; $display("FAIL random k=%0d got %b exp %b", k, obs, expected()); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_legal_cycle();
        test_conflict();
        test_yellow();
        test_encoding();
        test_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
